cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the execution units.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_rr.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus (CDB) arbiter.
//   ROB_WIDTH  : width of a reorder-buffer tag
//   CDB_DATA_W : width of a broadcast result
//   cdb_t      : the registered broadcast (valid, tag, data)
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH  = 4;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter.
// The request vector is searched starting at i_base and moving upward,
// wrapping from N-1 back to 0. The first set request wins.
// Ports:
//   i_req   [N]          request vector
//   i_base  [$clog2(N)]  index with highest priority this cycle
//   o_grant [N]          one-hot grant (all zero when nothing requests)
//   o_idx   [$clog2(N)]  index of the granted request
//   o_any                at least one request is set
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_base,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic          w_found;

  // (a + b) mod N. Both operands are < N, so one subtraction is enough.
  // This also holds when N is not a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                             input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
    return s[IW-1:0];
  endfunction

  always_comb begin
    // Rotate so that the base index lands on bit 0.
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      w_rot[i] = i_req[wrap_add(i_base, IW'(i))];
    end

    // Find the lowest set bit of the rotated vector.
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IW'(i);
      end
    end

    // Rotate the winner back to its absolute index.
    o_idx   = wrap_add(i_base, w_off);
    o_any   = w_found;
    o_grant = '0;
    if (w_found) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbiter for the common data bus (CDB).
// Execution units offer completed results. Each cycle, at most one unit is
// granted, in round-robin order. The granted result is broadcast from
// registers one cycle later, for the ROB and the reservation stations.
// Ports:
//   clk        core clock
//   reset      asynchronous reset, active-high
//   flush      synchronous pipeline flush; blocks grants and the next broadcast
//   req_valid  [N_UNITS]             unit i offers a result
//   req_ready  [N_UNITS]             grant to unit i (one-hot or zero)
//   req_tag    [N_UNITS][ROB_WIDTH]  ROB tag of each offered result
//   req_data   [N_UNITS][DATA_WIDTH] data of each offered result
//   cdb_valid                        broadcast valid
//   cdb_tag    [ROB_WIDTH]           broadcast ROB tag
//   cdb_data   [DATA_WIDTH]          broadcast data
//   grant_idx  [$clog2(N_UNITS)]     unit that produced the current broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_UNITS    = 4,
  parameter int DATA_WIDTH = CDB_DATA_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [N_UNITS-1:0]                   req_valid,
  output logic [N_UNITS-1:0]                   req_ready,
  input  logic [N_UNITS-1:0][ROB_WIDTH-1:0]    req_tag,
  input  logic [N_UNITS-1:0][DATA_WIDTH-1:0]   req_data,
  output logic                                 cdb_valid,
  output logic [ROB_WIDTH-1:0]                 cdb_tag,
  output logic [DATA_WIDTH-1:0]                cdb_data,
  output logic [$clog2(N_UNITS)-1:0]           grant_idx
);

  localparam int IW = $clog2(N_UNITS);

  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_gidx;
  cdb_t               r_cdb;

  logic [N_UNITS-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_xfer;
  logic [IW-1:0]      w_next_ptr;

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .i_req   (req_valid),
    .i_base  (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready depends combinationally on valid. It is forced low during reset
  // and during flush, so no transfer can happen in those cycles.
  assign req_ready  = (reset || flush) ? '0 : w_grant;
  assign w_xfer     = w_any && !flush;
  assign w_next_ptr = (w_idx == IW'(N_UNITS-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cdb  <= '0;
      r_gidx <= '0;
      r_ptr  <= '0;
    end else begin
      r_cdb.valid <= w_xfer;
      // Tag, data and index hold when nothing transfers. Consumers ignore
      // them while valid is low.
      if (w_xfer) begin
        r_cdb.tag  <= req_tag[w_idx];
        r_cdb.data <= req_data[w_idx];
        r_gidx     <= w_idx;
        r_ptr      <= w_next_ptr;
      end
    end
  end

  assign cdb_valid = r_cdb.valid;
  assign cdb_tag   = r_cdb.tag;
  assign cdb_data  = r_cdb.data;
  assign grant_idx = r_gidx;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       flush;
  logic [3:0]                 req_valid;
  logic [3:0]                 req_ready;
  logic [3:0][ROB_WIDTH-1:0]  req_tag;
  logic [3:0][31:0]           req_data;
  logic                       cdb_valid;
  logic [ROB_WIDTH-1:0]       cdb_tag;
  logic [31:0]                cdb_data;
  logic [1:0]                 grant_idx;

  int   errors = 0;
  int   checks = 0;
  logic oh_bad = 1'b0;

  cdb_arbiter #(.N_UNITS(4), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  // Sticky record of any cycle where req_ready was not one-hot or zero.
  always @(negedge clk) if (!$onehot0(req_ready)) oh_bad <= 1'b1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_tag[i]  = ROB_WIDTH'(i + 1);
      req_data[i] = 32'h5555_0000 + i;
    end
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", cdb_valid); end
    checks++; if (cdb_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d want 0", cdb_tag); end
    checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_gidx: got %0d want 0", grant_idx); end
    checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.r_ptr); end
    tick; tick;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_held: got %0b want 0", cdb_valid); end
    reset = 1'b0; req_valid = 4'b0000;
    tick;
  endtask

  task automatic test_single;
    req_tag[2] = ROB_WIDTH'(5); req_data[2] = 32'hDEADBEEF; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick;
    req_valid = 4'b0000;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", cdb_valid); end
    checks++; if (cdb_tag !== ROB_WIDTH'(5)) begin errors++; $display("FAIL single_tag: got %0d want 5", cdb_tag); end
    checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", cdb_data); end
    checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL single_gidx: got %0d want 2", grant_idx); end
    checks++; if (dut.r_ptr !== 2'd3) begin errors++; $display("FAIL single_ptr: got %0d want 3", dut.r_ptr); end
    tick;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %0b want 0", cdb_valid); end
  endtask

  task automatic test_back_to_back;
    int g;
    for (int i = 0; i < 4; i++) begin
      req_tag[i]  = ROB_WIDTH'(8 + i);
      req_data[i] = 32'hA000_0000 + i;
    end
    // Move the pointer from 3 to 0 with a single unit-3 transfer.
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL b2b_pre_ready: got %b want 1000", req_ready); end
    tick;
    checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL b2b_pre_ptr: got %0d want 0", dut.r_ptr); end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      #1;
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL b2b_ready%0d: got %b want %b", k, req_ready, 4'(1 << g)); end
      tick;
      checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %0b want 1", k, cdb_valid); end
      checks++; if (cdb_tag !== ROB_WIDTH'(8 + g)) begin errors++; $display("FAIL b2b_tag%0d: got %0d want %0d", k, cdb_tag, 8 + g); end
      checks++; if (cdb_data !== 32'hA000_0000 + g) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, cdb_data, 32'hA000_0000 + g); end
      checks++; if (grant_idx !== 2'(g)) begin errors++; $display("FAIL b2b_gidx%0d: got %0d want %0d", k, grant_idx, g); end
    end
    req_valid = 4'b0000;
    checks++; if (dut.r_ptr !== 2'd1) begin errors++; $display("FAIL b2b_ptr: got %0d want 1", dut.r_ptr); end
  endtask

  task automatic test_wrap;
    // Move the pointer from 1 to 2.
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_pre_ready: got %b want 0010", req_ready); end
    tick;
    checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL wrap_pre_ptr: got %0d want 2", dut.r_ptr); end
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b want 1000", req_ready); end
    tick;
    checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL wrap_gidx3: got %0d want 3", grant_idx); end
    checks++; if (cdb_tag !== ROB_WIDTH'(11)) begin errors++; $display("FAIL wrap_tag3: got %0d want 11", cdb_tag); end
    checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d want 0", dut.r_ptr); end
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready1: got %b want 0010", req_ready); end
    tick;
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL wrap_gidx1: got %0d want 1", grant_idx); end
    checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL wrap_ptr_end: got %0d want 2", dut.r_ptr); end
  endtask

  task automatic test_flush;
    req_valid = 4'b0011; flush = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b want 0000", req_ready); end
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL flush_inflight: got %0b want 1", cdb_valid); end
    tick;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", cdb_valid); end
    checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL flush_ptr: got %0d want 2", dut.r_ptr); end
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_after_ready: got %b want 0001", req_ready); end
    tick;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL flush_after_valid: got %0b want 1", cdb_valid); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL flush_after_gidx: got %0d want 0", grant_idx); end
    checks++; if (cdb_tag !== ROB_WIDTH'(8)) begin errors++; $display("FAIL flush_after_tag: got %0d want 8", cdb_tag); end
    checks++; if (dut.r_ptr !== 2'd1) begin errors++; $display("FAIL flush_after_ptr: got %0d want 1", dut.r_ptr); end
    req_valid = 4'b0010;
  endtask

  task automatic test_async_reset;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL areset_pre_ready: got %b want 0010", req_ready); end
    tick;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %0b want 1", cdb_valid); end
    req_valid = 4'b0110;
    #2 reset = 1'b1;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %0b want 0", cdb_valid); end
    checks++; if (dut.r_ptr !== 2'd0) begin errors++; $display("FAIL areset_ptr: got %0d want 0", dut.r_ptr); end
    checks++; if (cdb_tag !== '0) begin errors++; $display("FAIL areset_tag: got %0d want 0", cdb_tag); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL areset_gidx: got %0d want 0", grant_idx); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL areset_ready: got %b want 0000", req_ready); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL areset_post_ready: got %b want 0010", req_ready); end
    tick;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL areset_post_valid: got %0b want 1", cdb_valid); end
    checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL areset_post_gidx: got %0d want 1", grant_idx); end
    checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL areset_post_ptr: got %0d want 2", dut.r_ptr); end
  endtask

  task automatic test_idle;
    req_valid = 4'b0000;
    #1;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL idle_c1_valid: got %0b want 1", cdb_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
    for (int c = 2; c <= 3; c++) begin
      tick;
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL idle_c%0d_valid: got %0b want 0", c, cdb_valid); end
      checks++; if (dut.r_ptr !== 2'd2) begin errors++; $display("FAIL idle_c%0d_ptr: got %0d want 2", c, dut.r_ptr); end
      checks++; if (cdb_tag !== ROB_WIDTH'(9)) begin errors++; $display("FAIL idle_c%0d_tag_hold: got %0d want 9", c, cdb_tag); end
    end
    tick;
    checks++; if (oh_bad !== 1'b0) begin errors++; $display("FAIL ready_onehot0: got %0b want 0", oh_bad); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_wrap;
    test_flush;
    test_async_reset;
    test_idle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
